feature_row_reader: RTL
=======================

Name: feature_row_reader

Overview:
- Read-side controller for the ping-pong feature-row buffer.
- The write side fills one 80-entry row per bank and pulses row_done at each row wrap; this block drains completed rows in order and streams them downstream over a valid/ready handshake.
- It sits between the row buffer RAM (1-cycle read latency) and the next compute stage.
- It tracks row credits, bank/column/row position and frame completion.

Parameters:
- ROW_LEN, 80, entries per row; the column counter wraps at ROW_LEN-1.
- NUM_ROWS, 80, rows per frame.
- BANKS, 2, row-buffer banks; this is also the maximum number of row credits.
- DATA_W, 16, element width.
- ADDR_W, 8, RAM address width; must satisfy 2^ADDR_W >= BANKS*ROW_LEN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- row_done  in  1  one-cycle pulse: write side finished one row
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read address = bank*ROW_LEN + col
- rd_data  in  DATA_W  RAM data, valid the cycle after rd_en
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  output element
- out_last_col  out  1  element is column ROW_LEN-1
- out_last_row  out  1  element belongs to row NUM_ROWS-1
- frame_done  out  1  one-cycle pulse after the final element of a frame is accepted
- overflow  out  1  sticky: row_done arrived with credits==BANKS

Behaviour:
- Reset: all outputs 0; credits=0, col=0, bank=0, row=0, state IDLE, output FIFO empty, no read in flight. Reset mid-row discards in-flight and buffered data.
- Credits (0..BANKS) are updated every cycle:
  - row_done increments.
  - Issuing the read of column ROW_LEN-1 decrements.
  - Both in the same cycle: net unchanged.
  - row_done with credits==BANKS and no decrement: credits stay BANKS and overflow is set (cleared only by reset).
- States:
  - IDLE: go to READ when credits>0.
  - READ: issue reads, one element per rd_en.
  - After issuing column ROW_LEN-1: col->0, bank toggles mod BANKS, row increments (wraps to 0 after NUM_ROWS-1). Stay in READ if post-update credits>0, else go to IDLE.
  - Read issue is continuous across row boundaries; no bubble when credits remain.
- Output buffer:
  - 2-entry FIFO; rd_data is captured one cycle after rd_en.
  - rd_en is asserted only when in READ and (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready.
  - The FIFO never overflows; with out_ready held high, sustained throughput is 1 element/cycle.
- Output tags:
  - out_valid = FIFO not empty.
  - out_data, out_last_col and out_last_row are tagged at issue time and held stable while out_valid & !out_ready.
- Latency:
  - row_done with credits 0 -> rd_en 1 cycle later (IDLE->READ).
  - First out_valid 1 cycle after the first rd_en.
- frame_done: registered; asserted the cycle after pop of the element with out_last_col & out_last_row.

Optional Feature:
- Macro: FEATURE_ROW_READER_PERF_EN.
- When defined:
  - Extra output stall_cycles [15:0].
  - Increments, saturating at 0xFFFF, on each cycle with out_valid & !out_ready.
  - Cleared by reset and on the frame_done pulse.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single row, out_ready=1: one row_done pulse -> 80 rd_en cycles with addresses 0..79; 80 outputs on consecutive cycles; out_last_col only on the 80th; credits return to 0; state back to IDLE.
- Back-to-back rows: two row_done pulses 5 cycles apart -> 160 contiguous rd_en, addresses 0..79 then 80..159, no bubble at the row boundary.
- Backpressure: out_ready toggled 1,0,0,1 repeating -> every element delivered exactly once and in order, data held stable while stalled, rd_en never asserted when the FIFO plus in-flight count would exceed 2.
- Overflow: three row_done pulses with out_ready=0 -> credits saturate at 2 and overflow=1; overflow stays 1 after draining, until reset.
- Frame end: 80 rows streamed (NUM_ROWS=80) -> frame_done pulses exactly once, 1 cycle after the 6400th accept; row, bank and col wrap to 0; with FEATURE_ROW_READER_PERF_EN, stall_cycles reads the injected stall count then clears.
- Reset mid-row: assert reset at column 37 -> next cycle out_valid=0, rd_en=0, credits=0; a new row_done restarts the read at address 0.

Source files
------------

// File: rtl/feature_row_reader.sv
// feature_row_reader: read-side controller for the ping-pong feature-row buffer.
// Drains completed rows in order from the 1-cycle-latency row RAM and streams
// them downstream, tracking row credits, bank/column/row position and frame end.
// Optional build macro: FEATURE_ROW_READER_PERF_EN adds the stall_cycles counter.
//
// Handshake: an element transfers on every cycle where out_valid && out_ready.
// Once out_valid is raised, out_valid, out_data, out_last_col and out_last_row
// hold steady until that transfer happens.
module feature_row_reader #(
    parameter int ROW_LEN  = 80,
    parameter int NUM_ROWS = 80,
    parameter int BANKS    = 2,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         row_done,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic [DATA_W-1:0]            rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_last_col,
    output logic                         out_last_row,
    output logic                         frame_done,
    output logic                         overflow,
`ifdef FEATURE_ROW_READER_PERF_EN
    output logic [15:0]                  stall_cycles,
`endif
    output logic                         dbg_state,
    output logic [$clog2(BANKS+1)-1:0]   dbg_credits
);

    localparam int COL_W  = $clog2(ROW_LEN);
    localparam int ROW_W  = $clog2(NUM_ROWS);
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int CRED_W = $clog2(BANKS + 1);

    typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

    state_t              r_state, w_state_next;
    logic [CRED_W-1:0]   r_credits, w_credits_next;
    logic                w_ovf_set;
    logic [COL_W-1:0]    r_col;
    logic [BANK_W-1:0]   r_bank;
    logic [ROW_W-1:0]    r_row;
    logic                r_overflow;
    logic                r_frame_done;

    // One read may be in flight; its tags travel alongside it.
    logic                r_inflight, r_infl_lc, r_infl_lr;

    // Two-entry output FIFO.
    logic [DATA_W-1:0]   r_fifo_data [2];
    logic [1:0]          r_fifo_lc, r_fifo_lr;
    logic                r_wptr, r_rptr;
    logic [1:0]          r_count;

    logic                w_rd_en, w_last_issue, w_pop, w_bypass, w_push, w_fifo_pop;
    logic [2:0]          w_occ;

    // When the FIFO is empty the returning RAM word is presented directly, so
    // the first element appears the cycle after its read; if it is not taken
    // that cycle it is written into the FIFO and held from there.
    assign w_bypass     = (r_count == 2'd0) && r_inflight;
    assign out_valid    = (r_count != 2'd0) || r_inflight;
    assign out_data     = w_bypass ? rd_data   : r_fifo_data[r_rptr];
    assign out_last_col = w_bypass ? r_infl_lc : r_fifo_lc[r_rptr];
    assign out_last_row = w_bypass ? r_infl_lr : r_fifo_lr[r_rptr];
    assign w_pop        = out_valid && out_ready;
    assign w_push       = r_inflight && !(w_bypass && w_pop);
    assign w_fifo_pop   = w_pop && !w_bypass;

    // Buffered plus in-flight elements, after this cycle's pop, must leave room.
    assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en      = (r_state == S_READ) && (w_occ < 3'd2);
    assign w_last_issue = w_rd_en && (r_col == COL_W'(ROW_LEN - 1));

    assign rd_en        = w_rd_en;
    assign rd_addr      = ADDR_W'(r_bank) * ADDR_W'(ROW_LEN) + ADDR_W'(r_col);
    assign frame_done   = r_frame_done;
    assign overflow     = r_overflow;
    assign dbg_state    = r_state;
    assign dbg_credits  = r_credits;

    // Credit arithmetic: row_done adds, finishing a row's reads removes.
    always_comb begin
        w_credits_next = r_credits;
        w_ovf_set      = 1'b0;
        if (row_done && !w_last_issue) begin
            if (r_credits == CRED_W'(BANKS)) w_ovf_set = 1'b1;
            else                             w_credits_next = r_credits + CRED_W'(1);
        end else if (!row_done && w_last_issue) begin
            w_credits_next = r_credits - CRED_W'(1);
        end
    end

    // Credit counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credits  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_credits <= w_credits_next;
            if (w_ovf_set) r_overflow <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next state: leave IDLE as soon as a credit exists, return when none remain.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_credits_next != '0) w_state_next = S_READ;
            S_READ:  if (w_last_issue && (w_credits_next == '0)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Read position: column within row, bank and row within frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col  <= '0;
            r_bank <= '0;
            r_row  <= '0;
        end else if (w_rd_en) begin
            if (r_col == COL_W'(ROW_LEN - 1)) begin
                r_col  <= '0;
                r_bank <= (r_bank == BANK_W'(BANKS - 1)) ? '0 : r_bank + BANK_W'(1);
                r_row  <= (r_row == ROW_W'(NUM_ROWS - 1)) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // In-flight tracking and output FIFO storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight     <= 1'b0;
            r_infl_lc      <= 1'b0;
            r_infl_lr      <= 1'b0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_lc      <= '0;
            r_fifo_lr      <= '0;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_count        <= 2'd0;
        end else begin
            r_inflight <= w_rd_en;
            r_infl_lc  <= w_last_issue;
            r_infl_lr  <= (r_row == ROW_W'(NUM_ROWS - 1));
            if (w_push) begin
                r_fifo_data[r_wptr] <= rd_data;
                r_fifo_lc[r_wptr]   <= r_infl_lc;
                r_fifo_lr[r_wptr]   <= r_infl_lr;
                r_wptr              <= ~r_wptr;
            end
            if (w_fifo_pop) r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
        end
    end

    // Frame completion pulse, one cycle after the final element is taken.
    always_ff @(posedge clk) begin
        if (reset) r_frame_done <= 1'b0;
        else       r_frame_done <= w_pop && out_last_col && out_last_row;
    end

`ifdef FEATURE_ROW_READER_PERF_EN
    logic [15:0] r_stall_cycles;

    // Saturating count of cycles where an element waits on downstream.
    always_ff @(posedge clk) begin
        if (reset || r_frame_done)                                  r_stall_cycles <= '0;
        else if (out_valid && !out_ready && r_stall_cycles != 16'hFFFF) r_stall_cycles <= r_stall_cycles + 16'd1;
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
